// File: rtl/rice_core_pkg.sv
// Shared types for the rice_core CSR access path: CSR opcodes, the access FSM
// state encoding and the read-only CSR address test.
package rice_core_pkg;

  localparam int CSR_ADDR_W = 12;

  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } rice_core_csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_REQ,
    ST_READ_RSP,
    ST_WRITE_REQ,
    ST_WRITE_RSP,
    ST_DONE
  } rice_core_csr_state_e;

  // CSR numbers with [11:10] == 2'b11 are architecturally read-only.
  function automatic logic csr_is_read_only(input logic [CSR_ADDR_W-1:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/rice_bus_if.sv
// Simple request/response bus used between core initiators and rice_core_env slaves.
// Handshake: a request transfers on a cycle where request_valid && request_ready; a
// response on response_valid && response_ready. Once raised, request_valid and the
// request fields stay stable until accepted (an initiator-side flush may withdraw it).
interface rice_bus_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) ();
  logic              request_valid;
  logic              request_ready;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] write_data;
  logic              response_valid;
  logic              response_ready;
  logic [DATA_W-1:0] read_data;
  logic              error;

  modport master (
    output request_valid, address, write, write_data, response_ready,
    input  request_ready, response_valid, read_data, error
  );

  modport slave (
    input  request_valid, address, write, write_data, response_ready,
    output request_ready, response_valid, read_data, error
  );
endinterface

// File: rtl/rice_core_csr_access.sv
// CSR read-modify-write sequencer for CSRRW/CSRRS/CSRRC over rice_bus_if.
// Define RICE_CORE_CSR_RO_CHECK_EN to block write phases to read-only CSR numbers locally.
module rice_core_csr_access
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_csr_op,
  input  logic [CSR_ADDR_W-1:0] i_csr_address,
  input  logic [XLEN-1:0]       i_rs1_value,
  input  logic                  i_rs1_zero,
  input  logic                  i_rd_zero,
  output logic                  o_done,
  output logic [XLEN-1:0]       o_read_data,
  output logic                  o_illegal,
  output rice_core_csr_state_e  o_dbg_state,
  rice_bus_if.master            csr_if
);

`ifdef RICE_CORE_CSR_RO_CHECK_EN
  localparam logic RO_CHECK = 1'b1;
`else
  localparam logic RO_CHECK = 1'b0;
`endif

  rice_core_csr_state_e  state;
  rice_core_csr_op_e     op_q;
  rice_core_csr_op_e     req_op;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       rs1_q;
  logic                  rs1_zero_q;
  logic                  flushed_q;
  logic                  cancel;
  logic                  ro_fault_req;
  logic                  ro_fault_rsp;

  function automatic logic [XLEN-1:0] csr_alu(input rice_core_csr_op_e op,
                                              input logic [XLEN-1:0] old_val,
                                              input logic [XLEN-1:0] rs1);
    case (op)
      CSR_OP_RS: return old_val | rs1;
      CSR_OP_RC: return old_val & ~rs1;
      default:   return rs1;
    endcase
  endfunction

  assign req_op       = rice_core_csr_op_e'(i_csr_op);
  assign cancel       = flushed_q | i_flush;
  assign ro_fault_req = RO_CHECK && csr_is_read_only(i_csr_address);
  assign ro_fault_rsp = RO_CHECK && csr_is_read_only(addr_q);

  assign o_req_ready           = (state == ST_IDLE);
  assign o_dbg_state           = state;
  assign csr_if.response_ready = 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= ST_IDLE;
      op_q                 <= CSR_OP_RW;
      addr_q               <= '0;
      rs1_q                <= '0;
      rs1_zero_q           <= 1'b0;
      flushed_q            <= 1'b0;
      csr_if.request_valid <= 1'b0;
      csr_if.address       <= '0;
      csr_if.write         <= 1'b0;
      csr_if.write_data    <= '0;
      o_done               <= 1'b0;
      o_read_data          <= '0;
      o_illegal            <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A request arriving together with a flush belongs to the cancelled stream.
          if (i_req_valid && !i_flush) begin
            op_q        <= req_op;
            addr_q      <= i_csr_address;
            rs1_q       <= i_rs1_value;
            rs1_zero_q  <= i_rs1_zero;
            flushed_q   <= 1'b0;
            o_read_data <= '0;
            o_illegal   <= 1'b0;
            if (req_op == CSR_OP_RSVD || (req_op == CSR_OP_RW && i_rd_zero && ro_fault_req)) begin
              o_illegal <= 1'b1;
              o_done    <= 1'b1;
              state     <= ST_DONE;
            end else if (req_op == CSR_OP_RW && i_rd_zero) begin
              csr_if.request_valid <= 1'b1;
              csr_if.address       <= i_csr_address;
              csr_if.write         <= 1'b1;
              csr_if.write_data    <= i_rs1_value;
              state                <= ST_WRITE_REQ;
            end else begin
              csr_if.request_valid <= 1'b1;
              csr_if.address       <= i_csr_address;
              csr_if.write         <= 1'b0;
              state                <= ST_READ_REQ;
            end
          end
        end
        ST_READ_REQ, ST_WRITE_REQ: begin
          if (csr_if.request_ready) begin
            csr_if.request_valid <= 1'b0;
            flushed_q            <= i_flush;
            state                <= (state == ST_READ_REQ) ? ST_READ_RSP : ST_WRITE_RSP;
          end else if (i_flush) begin
            csr_if.request_valid <= 1'b0;
            state                <= ST_IDLE;
          end
        end
        ST_READ_RSP: begin
          if (csr_if.response_valid) begin
            o_read_data <= csr_if.read_data;
            if (cancel) begin
              state <= ST_IDLE;
            end else if (csr_if.error || ro_fault_rsp) begin
              o_illegal <= 1'b1;
              o_done    <= 1'b1;
              state     <= ST_DONE;
            end else if (rs1_zero_q && op_q != CSR_OP_RW) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              csr_if.request_valid <= 1'b1;
              csr_if.address       <= addr_q;
              csr_if.write         <= 1'b1;
              csr_if.write_data    <= csr_alu(op_q, csr_if.read_data, rs1_q);
              state                <= ST_WRITE_REQ;
            end
          end else if (i_flush) begin
            flushed_q <= 1'b1;
          end
        end
        ST_WRITE_RSP: begin
          if (csr_if.response_valid) begin
            if (cancel) begin
              state <= ST_IDLE;
            end else begin
              o_illegal <= csr_if.error;
              o_done    <= 1'b1;
              state     <= ST_DONE;
            end
          end else if (i_flush) begin
            flushed_q <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rice_core_csr_access.sv
// Directed bench for rice_core_csr_access with a small CSR slave and a write scoreboard.
module tb_rice_core_csr_access;
  import rice_core_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           csr_op;
  logic [11:0]          csr_addr;
  logic [31:0]          rs1_val;
  logic                 rs1_zero;
  logic                 rd_zero;
  logic                 done;
  logic [31:0]          rd_data;
  logic                 illegal;
  rice_core_csr_state_e dbg_state;

  rice_bus_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  rice_core_csr_access #(.XLEN(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_csr_op     (csr_op),
    .i_csr_address(csr_addr),
    .i_rs1_value  (rs1_val),
    .i_rs1_zero   (rs1_zero),
    .i_rd_zero    (rd_zero),
    .o_done       (done),
    .o_read_data  (rd_data),
    .o_illegal    (illegal),
    .o_dbg_state  (dbg_state),
    .csr_if       (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR slave: old value comes from rd_val, reads of 0x800 and writes to RO space error
  logic [31:0] rd_val;
  int          stall_cfg;
  int          stall_cnt;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;

  assign bus.request_ready  = (stall_cnt >= stall_cfg);
  assign bus.response_valid = rsp_valid;
  assign bus.read_data      = rsp_data;
  assign bus.error          = rsp_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if (bus.request_valid && !bus.request_ready) stall_cnt <= stall_cnt + 1;
      if (bus.request_valid && bus.request_ready) begin
        stall_cnt <= 0;
        rsp_valid <= 1'b1;
        if (bus.write) begin
          rsp_err  <= (bus.address[11:10] == 2'b11);
          rsp_data <= '0;
        end else begin
          rsp_err  <= (bus.address == 12'h800);
          rsp_data <= (bus.address == 12'h800) ? 32'h0 : rd_val;
        end
      end
    end
  end

  // scoreboard
  logic [43:0] exp_q[$];
  int          total;
  int          bad;
  int          stab_n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_monitor();
    logic        prev_stall;
    logic [44:0] prev_req;
    logic [43:0] e;
    prev_stall = 1'b0;
    prev_req   = '0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        stab_n++;
        check("stable_valid", 64'(bus.request_valid), 64'd1);
        check("stable_fields", 64'({bus.address, bus.write, bus.write_data}), 64'(prev_req));
      end
      prev_stall = bus.request_valid && !bus.request_ready;
      prev_req   = {bus.address, bus.write, bus.write_data};
      if (bus.request_valid && bus.request_ready && bus.write) begin
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_addr_data", 64'({bus.address, bus.write_data}), 64'(e));
        end
      end
    end
  endtask

  // driver
  task automatic do_csr(input string tag, input logic [1:0] op, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic rs1z, input logic rdz,
                        input logic [31:0] exp_rd, input logic exp_ill, input int exp_lat);
    int lat;
    lat       = -1;
    csr_op    = op;
    csr_addr  = addr;
    rs1_val   = rs1;
    rs1_zero  = rs1z;
    rd_zero   = rdz;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_read_data"}, 64'(rd_data), 64'(exp_rd));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    check({tag, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int dones;
    int wait_n;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; csr_op = 2'b00; csr_addr = '0;
    rs1_val = '0; rs1_zero = 1'b0; rd_zero = 1'b0; rd_val = '0; stall_cfg = 0;
    total = 0; bad = 0; stab_n = 0;
    fork
      bus_monitor();
    join_none
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_read_data", 64'(rd_data), 64'd0);
    check("rst_req_valid", 64'(bus.request_valid), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // CSRRW full read-modify-write
    rd_val = 32'h0000_1234;
    exp_q.push_back({12'h340, 32'hA5A5_0000});
    do_csr("rw", 2'b01, 12'h340, 32'hA5A5_0000, 1'b0, 1'b0, 32'h1234, 1'b0, 4);
    repeat (3) @(negedge clk);
    check("rw_hold_read_data", 64'(rd_data), 64'h1234);

    // CSRRS with and without a write phase
    rd_val = 32'h0000_1800;
    exp_q.push_back({12'h300, 32'h0000_1808});
    do_csr("rs", 2'b10, 12'h300, 32'h8, 1'b0, 1'b0, 32'h1800, 1'b0, 4);
    rd_val = 32'h0000_1808;
    do_csr("rs_zero", 2'b10, 12'h300, 32'h0, 1'b1, 1'b0, 32'h1808, 1'b0, 2);

    // CSRRC with the slave stalling each request for 3 cycles
    rd_val    = 32'h0000_00FF;
    stall_cfg = 3;
    exp_q.push_back({12'h341, 32'h0000_00F0});
    do_csr("rc_stall", 2'b11, 12'h341, 32'hF, 1'b0, 1'b0, 32'hFF, 1'b0, 10);
    stall_cfg = 0;
    check("rc_stall_cycles", 64'(stab_n), 64'd6);

    // read error from the slave
    do_csr("rd_err", 2'b10, 12'h800, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 2);

    // CSRRW to a read-only CSR
    rd_val = 32'h0000_0005;
`ifdef RICE_CORE_CSR_RO_CHECK_EN
    do_csr("ro_rw", 2'b01, 12'hF14, 32'h77, 1'b0, 1'b0, 32'h5, 1'b1, 2);
`else
    exp_q.push_back({12'hF14, 32'h0000_0077});
    do_csr("ro_rw", 2'b01, 12'hF14, 32'h77, 1'b0, 1'b0, 32'h5, 1'b1, 4);
`endif

    // CSRRW with rd=x0 skips the read
    exp_q.push_back({12'h305, 32'h0000_0100});
    do_csr("rw_rd0", 2'b01, 12'h305, 32'h100, 1'b0, 1'b1, 32'h0, 1'b0, 2);

    // reserved opcode
    do_csr("rsvd_op", 2'b00, 12'h340, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 0);

    // flush while the read response is outstanding
    rd_val    = 32'h0000_0009;
    csr_op    = 2'b10; csr_addr = 12'h342; rs1_val = 32'h1; rs1_zero = 1'b0; rd_zero = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 64'(req_ready), 64'd1);
    check("flush_state", 64'(dbg_state), 64'(ST_IDLE));
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_no_write", 64'(exp_q.size()), 64'd0);

    // reset while waiting for the write response
    rd_val = 32'h0000_0001;
    exp_q.push_back({12'h343, 32'h0000_0003});
    csr_op    = 2'b10; csr_addr = 12'h343; rs1_val = 32'h2;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_n = 0;
    while (dbg_state != ST_WRITE_RSP && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check("wrsp_reached", 64'(dbg_state), 64'(ST_WRITE_RSP));
    check("wrsp_read_data", 64'(rd_data), 64'h1);
    rst_n = 1'b0;
    #1;
    check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("arst_read_data", 64'(rd_data), 64'd0);
    check("arst_illegal", 64'(illegal), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_req_valid", 64'(bus.request_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready_after", 64'(req_ready), 64'd1);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
